// File: rtl/bmp_copy_ctrl.sv
// bmp_copy_ctrl: streams a stored BMP from synchronous ROM into RAM,
// capturing and validating the 54-byte header on the way.
module bmp_copy_ctrl #(
  parameter int BYTE_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 20,
  parameter int BMP_TOTAL_SIZE = 786486
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [BYTE_WIDTH-1:0] ROM_Q,
  output logic                  ROM_valid,
  output logic [ADDR_WIDTH-1:0] ROM_addr,
  output logic                  RAM_valid,
  output logic [BYTE_WIDTH-1:0] RAM_D,
  output logic [ADDR_WIDTH-1:0] RAM_addr,
  output logic                  pix_en,
  output logic [31:0]           img_width,
  output logic [31:0]           img_height,
  output logic [31:0]           pix_offset,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    DONE,
    ERR
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(BMP_TOTAL_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] HDR_LEN = ADDR_WIDTH'(54);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(1);
  localparam logic [31:0] SIZE32 = 32'(BMP_TOTAL_SIZE);

  state_t state, state_d;

  logic                  rom_v_d;
  logic [ADDR_WIDTH-1:0] rom_a_d;
  logic                  ram_v_d;
  logic [ADDR_WIDTH-1:0] ram_a_d;
  logic                  done_d;
  logic                  err_d;
  logic [31:0]           off_d;
  logic [31:0]           wid_d;
  logic [31:0]           hgt_d;
  logic [7:0]            bpp_lo;
  logic [7:0]            bpp_d;
  logic                  off_ok;
  logic                  off_ok_d;

  logic [7:0]  hb;
  logic [5:0]  k;
  logic [4:0]  bsel;
  logic        is_hdr;
  logic        hdr_bad;
  logic [31:0] off_full;
  logic [31:0] addr32;

  // The byte on ROM_Q belongs to the write currently on the RAM port.
  assign hb       = ROM_Q[7:0];
  assign k        = RAM_addr[5:0];
  assign is_hdr   = RAM_valid && (RAM_addr < HDR_LEN);
  assign bsel     = {k[1:0] - 2'd2, 3'b000};
  assign off_full = {hb, pix_offset[23:0]};
  assign addr32   = {{(32 - ADDR_WIDTH){1'b0}}, RAM_addr};

  assign RAM_D  = RAM_valid ? ROM_Q : '0;
  assign pix_en = RAM_valid && off_ok && (addr32 >= pix_offset);

  assign hdr_bad = is_hdr && (
    ((k == 6'd0) && (hb != 8'h42)) ||
    ((k == 6'd1) && (hb != 8'h4D)) ||
    ((k == 6'd13) &&
     ((off_full < 32'd54) || (off_full >= SIZE32))) ||
    ((k == 6'd29) && ({hb, bpp_lo} != 16'd24)));

  always_comb begin
    state_d  = state;
    rom_v_d  = ROM_valid;
    rom_a_d  = ROM_addr;
    ram_v_d  = 1'b0;
    ram_a_d  = RAM_addr;
    done_d   = done;
    err_d    = err;
    off_d    = pix_offset;
    wid_d    = img_width;
    hgt_d    = img_height;
    bpp_d    = bpp_lo;
    off_ok_d = off_ok;

    // Header fields 10, 18 and 22 all start at byte lane 2 mod 4.
    if (is_hdr) begin
      unique case (1'b1)
        (k >= 6'd10) && (k <= 6'd13): off_d[bsel +: 8] = hb;
        (k >= 6'd18) && (k <= 6'd21): wid_d[bsel +: 8] = hb;
        (k >= 6'd22) && (k <= 6'd25): hgt_d[bsel +: 8] = hb;
        (k == 6'd28):                 bpp_d = hb;
        default: ;
      endcase
      if (k == 6'd13) off_ok_d = 1'b1;
    end

    unique case (state)
      IDLE, DONE, ERR: begin
        if (in_valid) begin
          state_d  = READ;
          rom_v_d  = 1'b1;
          rom_a_d  = '0;
          done_d   = 1'b0;
          err_d    = 1'b0;
          off_d    = '0;
          wid_d    = '0;
          hgt_d    = '0;
          bpp_d    = '0;
          off_ok_d = 1'b0;
        end
      end
      READ: begin
        ram_v_d = 1'b1;
        ram_a_d = ROM_addr;
        if (ROM_addr == LAST) begin
          rom_v_d = 1'b0;
          state_d = DRAIN;
        end else begin
          rom_a_d = ROM_addr + STEP;
        end
      end
      DRAIN: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // A bad header byte is still written; the in-flight read is dropped.
    if (hdr_bad) begin
      state_d = ERR;
      rom_v_d = 1'b0;
      ram_v_d = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ROM_valid  <= 1'b0;
      ROM_addr   <= '0;
      RAM_valid  <= 1'b0;
      RAM_addr   <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      pix_offset <= '0;
      img_width  <= '0;
      img_height <= '0;
      bpp_lo     <= '0;
      off_ok     <= 1'b0;
    end else begin
      state      <= state_d;
      ROM_valid  <= rom_v_d;
      ROM_addr   <= rom_a_d;
      RAM_valid  <= ram_v_d;
      RAM_addr   <= ram_a_d;
      done       <= done_d;
      err        <= err_d;
      pix_offset <= off_d;
      img_width  <= wid_d;
      img_height <= hgt_d;
      bpp_lo     <= bpp_d;
      off_ok     <= off_ok_d;
    end
  end

endmodule

// File: tb/tb_bmp_copy_ctrl.sv
// tb_bmp_copy_ctrl: random and directed BMP images copied through the
// controller, checked cycle by cycle against a header-rule model.
module tb_bmp_copy_ctrl;

  localparam int SIZE = 70;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  ROM_Q;
  logic        ROM_valid;
  logic [19:0] ROM_addr;
  logic        RAM_valid;
  logic [7:0]  RAM_D;
  logic [19:0] RAM_addr;
  logic        pix_en;
  logic [31:0] img_width;
  logic [31:0] img_height;
  logic [31:0] pix_offset;
  logic        done;
  logic        err;

  logic [7:0] img [0:SIZE-1];
  int n_checks = 0;
  int n_fail = 0;

  bmp_copy_ctrl #(
    .BYTE_WIDTH(8),
    .ADDR_WIDTH(20),
    .BMP_TOTAL_SIZE(SIZE)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .ROM_Q(ROM_Q),
    .ROM_valid(ROM_valid),
    .ROM_addr(ROM_addr),
    .RAM_valid(RAM_valid),
    .RAM_D(RAM_D),
    .RAM_addr(RAM_addr),
    .pix_en(pix_en),
    .img_width(img_width),
    .img_height(img_height),
    .pix_offset(pix_offset),
    .done(done),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (ROM_valid && int'(ROM_addr) < SIZE)
      ROM_Q <= img[int'(ROM_addr)];

  function automatic logic [31:0] le32(int lo, int last);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 4; i++)
      if (lo + i <= last) v[8*i +: 8] = img[lo + i];
    return v;
  endfunction

  // First header byte that breaks the BMP rules, or -1.
  function automatic int first_fail();
    logic [31:0] off;
    logic [15:0] bpp;
    off = le32(10, 13);
    bpp = {img[29], img[28]};
    if (img[0] != 8'h42) return 0;
    if (img[1] != 8'h4D) return 1;
    if (off < 32'd54 || off >= 32'(SIZE)) return 13;
    if (bpp != 16'd24) return 29;
    return -1;
  endfunction

  task automatic make_image(input logic [31:0] off, input logic [31:0] w,
                            input logic [31:0] h, input logic [15:0] bpp);
    for (int i = 0; i < SIZE; i++) img[i] = 8'($urandom);
    img[0] = 8'h42;
    img[1] = 8'h4D;
    for (int i = 0; i < 4; i++) begin
      img[10 + i] = off[8*i +: 8];
      img[18 + i] = w[8*i +: 8];
      img[22 + i] = h[8*i +: 8];
    end
    img[28] = bpp[7:0];
    img[29] = bpp[15:8];
  endtask

  task automatic run_copy(input bit hold, input string tag);
    int f, last_w, last_r, end_c, a;
    logic [31:0] off;
    logic ev;
    logic [4:0] obs, exp;
    f = first_fail();
    last_w = (f < 0) ? SIZE - 1 : f;
    last_r = (f < 0) ? last_w : last_w + 1;
    end_c = (f < 0) ? SIZE + 1 : f + 2;
    off = le32(10, 13);
    in_valid = 1'b1;
    for (int c = 0; c <= end_c + 3; c++) begin
      @(negedge clk);
      if (c == 0 && !hold) in_valid = 1'b0;
      if (c == end_c) in_valid = 1'b0;
      a = c - 1;
      ev = (c >= 1) && (c <= last_w + 1);
      exp = {c <= last_r, ev,
             ev && a > 13 && 32'(a) >= off,
             f < 0 && c >= end_c, f >= 0 && c >= end_c};
      obs = {ROM_valid, RAM_valid, pix_en, done, err};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL %s ctl c=%0d {romv,ramv,pix,done,err} got %b exp %b",
                 tag, c, obs, exp);
      end
      if (c <= last_r) begin
        n_checks++;
        if (ROM_addr !== 20'(c)) begin
          n_fail++;
          $display("FAIL %s rom_addr c=%0d got %0d exp %0d",
                   tag, c, ROM_addr, c);
        end
      end
      if (ev) begin
        n_checks++;
        if ({RAM_addr, RAM_D} !== {20'(a), img[a]}) begin
          n_fail++;
          $display("FAIL %s ram_wr c=%0d got %0d/%h exp %0d/%h",
                   tag, c, RAM_addr, RAM_D, a, img[a]);
        end
      end
    end
    n_checks++;
    if ({img_width, img_height, pix_offset} !==
        {le32(18, last_w), le32(22, last_w), le32(10, last_w)}) begin
      n_fail++;
      $display("FAIL %s fields got %h/%h/%h exp %h/%h/%h", tag,
               img_width, img_height, pix_offset,
               le32(18, last_w), le32(22, last_w), le32(10, last_w));
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({ROM_valid, RAM_valid, pix_en, done, err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset ctl got %b exp 00000",
               {ROM_valid, RAM_valid, pix_en, done, err});
    end
    n_checks++;
    if ({ROM_addr, RAM_addr, RAM_D} !== 48'b0) begin
      n_fail++;
      $display("FAIL reset addr/data got %h %h %h exp 0",
               ROM_addr, RAM_addr, RAM_D);
    end
    n_checks++;
    if ({img_width, img_height, pix_offset} !== 96'b0) begin
      n_fail++;
      $display("FAIL reset fields got %h %h %h exp 0",
               img_width, img_height, pix_offset);
    end
  endtask

  task automatic test_valid_copy();
    make_image(32'd54, 32'd4, 32'd1, 16'd24);
    run_copy(1'b0, "valid");
    n_checks++;
    if ({img_width, img_height, pix_offset} !==
        {32'd4, 32'd1, 32'd54}) begin
      n_fail++;
      $display("FAIL valid_hdr got %0d/%0d/%0d exp 4/1/54",
               img_width, img_height, pix_offset);
    end
    n_checks++;
    if ({done, err} !== 2'b10) begin
      n_fail++;
      $display("FAIL valid_status done/err got %b exp 10", {done, err});
    end
  endtask

  task automatic test_bad_magic();
    make_image(32'd54, 32'd4, 32'd1, 16'd24);
    img[1] = 8'h4E;
    run_copy(1'b0, "bad_magic");
    n_checks++;
    if ({done, err, ROM_valid, RAM_valid} !== 4'b0100) begin
      n_fail++;
      $display("FAIL bad_magic status got %b exp 0100",
               {done, err, ROM_valid, RAM_valid});
    end
  endtask

  task automatic test_bad_bpp();
    make_image(32'd54, 32'd4, 32'd1, 16'd8);
    run_copy(1'b0, "bad_bpp");
    n_checks++;
    if ({done, err} !== 2'b01) begin
      n_fail++;
      $display("FAIL bad_bpp status got %b exp 01", {done, err});
    end
  endtask

  task automatic test_bad_offset();
    make_image(32'(SIZE), 32'd4, 32'd1, 16'd24);
    run_copy(1'b0, "bad_off");
    n_checks++;
    if ({done, err, pix_offset} !== {2'b01, 32'(SIZE)}) begin
      n_fail++;
      $display("FAIL bad_off status got %b off %0d exp 01 off %0d",
               {done, err}, pix_offset, SIZE);
    end
  endtask

  task automatic test_reset_mid_copy();
    bit hit;
    hit = 1'b0;
    make_image(32'd54, 32'd4, 32'd1, 16'd24);
    in_valid = 1'b1;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (RAM_valid && RAM_addr == 20'd30) hit = 1'b1;
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL mid_reset write of addr 30 got none exp one");
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ROM_valid, RAM_valid, pix_en, done, err, ROM_addr, RAM_addr,
         RAM_D, img_width, img_height, pix_offset} !== 149'b0) begin
      n_fail++;
      $display("FAIL mid_reset outputs got %b%b%b%b%b %h %h %h exp all 0",
               ROM_valid, RAM_valid, pix_en, done, err,
               ROM_addr, RAM_addr, RAM_D);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_copy(1'b0, "post_reset");
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset done got %b exp 1", done);
    end
  endtask

  task automatic test_back_to_back();
    make_image(32'd60, $urandom, $urandom, 16'd24);
    run_copy(1'b1, "hold");
    run_copy(1'b0, "again");
    n_checks++;
    if ({done, err} !== 2'b10) begin
      n_fail++;
      $display("FAIL again status got %b exp 10", {done, err});
    end
  endtask

  task automatic test_random(input int n);
    int kind;
    logic [31:0] off;
    for (int i = 0; i < n; i++) begin
      kind = $urandom_range(0, 5);
      off = 32'(54 + $urandom_range(0, SIZE - 55));
      if (kind == 4) off = 32'($urandom_range(0, 53));
      if (kind == 5) off = 32'(SIZE) + 32'($urandom_range(0, 5000));
      make_image(off, $urandom, $urandom, 16'd24);
      if (kind == 1) img[0] = img[0] ^ 8'($urandom_range(1, 255));
      if (kind == 2) img[1] = img[1] ^ 8'($urandom_range(1, 255));
      if (kind == 3) img[28 + int'($urandom_range(0, 1))] ^= 8'h10;
      run_copy(1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < SIZE; i++) img[i] = 8'h00;
    #1;
    test_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_valid_copy();
    test_bad_magic();
    test_bad_bpp();
    test_bad_offset();
    test_reset_mid_copy();
    test_back_to_back();
    test_random(12);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
